cp0_cause_timer: RTL and testbench

- Generalised CP0 Cause unit with an integrated Count/Compare timer and interrupt-request generation.
- Owns the Cause register (BD, TI, IP[7:0], ExcCode), the Count and Compare registers, and a registered interrupt request to the exception pipeline stage.
- Sits beside the CP0 Status register; it consumes Status.IE, Status.EXL and Status.IM.

---
 rtl/cp0_cause_timer.sv | 147 ++++++++++++++
 tb/tb_cp0_cause_timer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_cause_timer.sv
// CP0 Cause register with Count/Compare timer and registered interrupt request.
// Optional macro CP0_IRQ_SYNC_EN adds a 2-flop synchronizer on every hw_int line.
module cp0_cause_timer #(
  parameter int HW_IRQ_NUM = 6,
  parameter int COUNT_DIV  = 2,
  parameter int TIMER_IP   = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mtc0_we,
  input  logic [7:0]            cp0_addr,
  input  logic [31:0]           mtc0_data,
  input  logic                  exception,
  input  logic [4:0]            exc_code,
  input  logic                  bd,
  input  logic                  status_ie,
  input  logic                  status_exl,
  input  logic [7:0]            status_im,
  input  logic [HW_IRQ_NUM-1:0] hw_int,
  output logic [31:0]           cause_data,
  output logic [31:0]           count_data,
  output logic [31:0]           compare_data,
  output logic [31:0]           cp0_rdata,
  output logic                  int_req
);

  localparam logic [7:0] ADDR_COUNT   = 8'h48;
  localparam logic [7:0] ADDR_COMPARE = 8'h58;
  localparam logic [7:0] ADDR_CAUSE   = 8'h68;
  localparam logic [3:0] DIV_LAST     = 4'(COUNT_DIV - 1);

  logic [3:0]            div_q;
  logic                  tick;
  logic [31:0]           count_q;
  logic [31:0]           compare_q;
  logic                  ti_q;
  logic                  ti_next;
  logic                  bd_q;
  logic [4:0]            exc_q;
  logic [5:0]            ip_hw_q;
  logic [5:0]            ip_hw_next;
  logic [5:0]            hw_pad;
  logic [1:0]            ip_sw_q;
  logic [7:0]            cause_ip;
  logic                  int_req_q;
  logic                  wr_count;
  logic                  wr_compare;
  logic                  wr_cause;
  logic [HW_IRQ_NUM-1:0] hw_src;

  assign wr_count   = mtc0_we && (cp0_addr == ADDR_COUNT);
  assign wr_compare = mtc0_we && (cp0_addr == ADDR_COMPARE);
  assign wr_cause   = mtc0_we && (cp0_addr == ADDR_CAUSE);
  assign tick       = (div_q == DIV_LAST);

`ifdef CP0_IRQ_SYNC_EN
  logic [HW_IRQ_NUM-1:0] sync1_q;
  logic [HW_IRQ_NUM-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= hw_int;
      sync2_q <= sync1_q;
    end
  end

  assign hw_src = sync2_q;
`else
  assign hw_src = hw_int;
`endif

  // A Count write restarts the prescaler and suppresses the tick in that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      div_q   <= '0;
    end else if (wr_count) begin
      count_q <= mtc0_data;
      div_q   <= '0;
    end else begin
      if (tick) count_q <= count_q + 32'd1;
      div_q <= tick ? 4'd0 : div_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) compare_q <= '0;
    else if (wr_compare) compare_q <= mtc0_data;
  end

  // Compare write has priority over a simultaneous match.
  always_comb begin
    ti_next = ti_q;
    if (tick && !wr_count && ((count_q + 32'd1) == compare_q)) ti_next = 1'b1;
    if (wr_compare) ti_next = 1'b0;
  end

  always_comb begin
    hw_pad = '0;
    hw_pad[HW_IRQ_NUM-1:0] = hw_src;
    ip_hw_next = hw_pad | (6'(ti_next) << (TIMER_IP - 2));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ti_q    <= 1'b0;
      ip_hw_q <= '0;
      ip_sw_q <= '0;
      bd_q    <= 1'b0;
      exc_q   <= '0;
    end else begin
      ti_q    <= ti_next;
      ip_hw_q <= ip_hw_next;
      if (wr_cause) ip_sw_q <= mtc0_data[9:8];
      if (exception) begin
        exc_q <= exc_code;
        if (!status_exl) bd_q <= bd;
      end
    end
  end

  assign cause_ip = {ip_hw_q, ip_sw_q};

  always_ff @(posedge clk) begin
    if (!rst_n) int_req_q <= 1'b0;
    else        int_req_q <= status_ie & ~status_exl & (|(cause_ip & status_im));
  end

  assign cause_data   = {bd_q, ti_q, 14'b0, cause_ip, 1'b0, exc_q, 2'b0};
  assign count_data   = count_q;
  assign compare_data = compare_q;
  assign int_req      = int_req_q;

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      ADDR_COUNT:   cp0_rdata = count_q;
      ADDR_COMPARE: cp0_rdata = compare_q;
      ADDR_CAUSE:   cp0_rdata = cause_data;
      default:      cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_cause_timer.sv
// Scoreboard bench for cp0_cause_timer: stimulus queues expected values tagged with
// a target cycle, a negedge monitor pops and compares them.
module tb_cp0_cause_timer;

  localparam int SEL_CAUSE   = 0;
  localparam int SEL_COUNT   = 1;
  localparam int SEL_COMPARE = 2;
  localparam int SEL_RDATA   = 3;
  localparam int SEL_IRQ     = 4;
`ifdef CP0_IRQ_SYNC_EN
  localparam int HW_LAT = 3;
`else
  localparam int HW_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mtc0_we;
  logic [7:0]  cp0_addr;
  logic [31:0] mtc0_data;
  logic        exception;
  logic [4:0]  exc_code;
  logic        bd;
  logic        status_ie;
  logic        status_exl;
  logic [7:0]  status_im;
  logic [5:0]  hw_int;
  logic [31:0] cause_data;
  logic [31:0] count_data;
  logic [31:0] compare_data;
  logic [31:0] cp0_rdata;
  logic        int_req;

  cp0_cause_timer dut (
    .clk(clk), .rst_n(rst_n), .mtc0_we(mtc0_we), .cp0_addr(cp0_addr),
    .mtc0_data(mtc0_data), .exception(exception), .exc_code(exc_code), .bd(bd),
    .status_ie(status_ie), .status_exl(status_exl), .status_im(status_im),
    .hw_int(hw_int), .cause_data(cause_data), .count_data(count_data),
    .compare_data(compare_data), .cp0_rdata(cp0_rdata), .int_req(int_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] mask;
    logic [31:0] exp;
  } exp_t;

  exp_t  sb[$];
  string nm[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dut_val(input int sel);
    case (sel)
      SEL_CAUSE:   return cause_data;
      SEL_COUNT:   return count_data;
      SEL_COMPARE: return compare_data;
      SEL_RDATA:   return cp0_rdata;
      default:     return {31'b0, int_req};
    endcase
  endfunction

  // Monitor: compare every expectation whose target cycle has arrived.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t  e;
        string n;
        logic [31:0] act;
        e = sb.pop_front();
        n = nm.pop_front();
        act = dut_val(e.sel) & e.mask;
        checks++;
        if (e.cyc != cyc) begin
          failures++;
          $display("[TB] FAIL %s: stale entry for cycle %0d seen at cycle %0d", n, e.cyc, cyc);
        end else if (act !== (e.exp & e.mask)) begin
          failures++;
          $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (mask 0x%08h)", n, act, e.exp & e.mask, e.mask);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int delay, input int sel, input logic [31:0] mask,
                             input logic [31:0] exp, input string name);
    exp_t e;
    int   pos;
    e.cyc = cyc + delay;
    e.sel = sel;
    e.mask = mask;
    e.exp = exp;
    pos = sb.size();
    while (pos > 0 && sb[pos-1].cyc > e.cyc) pos--;
    sb.insert(pos, e);
    nm.insert(pos, name);
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data);
    mtc0_we   = 1'b1;
    cp0_addr  = addr;
    mtc0_data = data;
    step(1);
    mtc0_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; mtc0_we = 1'b0; cp0_addr = 8'h00; mtc0_data = '0;
    exception = 1'b0; exc_code = '0; bd = 1'b0;
    status_ie = 1'b0; status_exl = 1'b0; status_im = 8'h00; hw_int = '0;
    step(3);
    checkOutput(0, SEL_CAUSE,   32'hFFFFFFFF, 32'h0, "reset_cause");
    checkOutput(0, SEL_COUNT,   32'hFFFFFFFF, 32'h0, "reset_count");
    checkOutput(0, SEL_COMPARE, 32'hFFFFFFFF, 32'h0, "reset_compare");
    checkOutput(0, SEL_IRQ,     32'h1,        32'h0, "reset_int_req");

    // Free-running count: 10 cycles at divide-by-2.
    rst_n = 1'b1;
    checkOutput(10, SEL_COUNT, 32'hFFFFFFFF, 32'd5, "count_after_10");
    checkOutput(10, SEL_CAUSE, 32'hFFFFFFFF, 32'h0, "cause_idle");
    checkOutput(10, SEL_IRQ,   32'h1,        32'h0, "irq_idle");
    step(10);

    // Timer match sets TI / IP7, int_req one cycle later.
    status_ie = 1'b1; status_exl = 1'b0; status_im = 8'h80;
    applyStimulus(8'h48, 32'h10);
    applyStimulus(8'h58, 32'h12);
    checkOutput(0, SEL_COMPARE, 32'hFFFFFFFF, 32'h12,       "compare_write");
    checkOutput(0, SEL_RDATA,   32'hFFFFFFFF, 32'h12,       "rdata_compare");
    checkOutput(2, SEL_CAUSE,   32'h40008000, 32'h0,        "ti_before_match");
    checkOutput(3, SEL_COUNT,   32'hFFFFFFFF, 32'h12,       "count_at_match");
    checkOutput(3, SEL_CAUSE,   32'h40008000, 32'h40008000, "ti_ip7_set");
    checkOutput(3, SEL_IRQ,     32'h1,        32'h0,        "irq_not_yet");
    checkOutput(4, SEL_IRQ,     32'h1,        32'h1,        "irq_from_ti");
    step(5);
    applyStimulus(8'h58, 32'h100);
    checkOutput(0, SEL_CAUSE, 32'h40008000, 32'h0, "ti_cleared");
    checkOutput(1, SEL_IRQ,   32'h1,        32'h0, "irq_cleared");
    step(2);

    // Count wrap onto Compare=0 sets TI.
    applyStimulus(8'h48, 32'hFFFFFFFF);
    applyStimulus(8'h58, 32'h0);
    checkOutput(0, SEL_CAUSE, 32'h40000000, 32'h0,        "ti_pre_wrap");
    checkOutput(1, SEL_COUNT, 32'hFFFFFFFF, 32'h0,        "count_wrap");
    checkOutput(1, SEL_CAUSE, 32'h40008000, 32'h40008000, "ti_on_wrap");
    step(2);

    // Writing Count equal to Compare never sets TI.
    applyStimulus(8'h58, 32'h30);
    applyStimulus(8'h48, 32'h30);
    checkOutput(0, SEL_COUNT, 32'hFFFFFFFF, 32'h30, "count_eq_compare");
    checkOutput(0, SEL_CAUSE, 32'h40000000, 32'h0,  "ti_no_set_on_write");
    checkOutput(2, SEL_COUNT, 32'hFFFFFFFF, 32'h31, "count_after_eq");
    checkOutput(3, SEL_CAUSE, 32'h40000000, 32'h0,  "ti_still_clear");
    step(4);
    cp0_addr = 8'h50;
    checkOutput(0, SEL_RDATA, 32'hFFFFFFFF, 32'h0, "rdata_unmapped");
    step(1);

    // Hardware interrupt line 0 -> IP2 -> int_req.
    status_im = 8'h04;
    hw_int = 6'b000001;
    checkOutput(HW_LAT,     SEL_CAUSE, 32'h00000400, 32'h400, "ip2_set");
    checkOutput(HW_LAT,     SEL_IRQ,   32'h1,        32'h0,   "hw_irq_not_yet");
    checkOutput(HW_LAT + 1, SEL_IRQ,   32'h1,        32'h1,   "hw_irq");
    step(HW_LAT + 2);
    hw_int = '0;
    step(HW_LAT + 2);
    status_exl = 1'b1;
    hw_int = 6'b000001;
    checkOutput(HW_LAT,     SEL_CAUSE, 32'h00000400, 32'h400, "ip2_set_exl");
    checkOutput(HW_LAT + 1, SEL_IRQ,   32'h1,        32'h0,   "hw_irq_masked_exl");
    checkOutput(HW_LAT + 2, SEL_IRQ,   32'h1,        32'h0,   "hw_irq_masked_exl2");
    step(HW_LAT + 3);
    hw_int = '0;
    status_exl = 1'b0;
    step(HW_LAT + 2);

    // Exception commits: BD latched only when EXL is clear.
    exception = 1'b1; exc_code = 5'h0C; bd = 1'b1; status_exl = 1'b0;
    step(1);
    exception = 1'b0;
    checkOutput(0, SEL_CAUSE, 32'hFFFFFFFF, 32'h80000030, "exc_bd_set");
    step(1);
    exception = 1'b1; exc_code = 5'h04; bd = 1'b0; status_exl = 1'b1;
    step(1);
    exception = 1'b0;
    checkOutput(0, SEL_CAUSE, 32'hFFFFFFFF, 32'h80000010, "exc_bd_hold");
    step(1);

    // MTC0 Cause and exception in the same cycle touch disjoint fields.
    exception = 1'b1; exc_code = 5'h08; bd = 1'b0; status_exl = 1'b1;
    applyStimulus(8'h68, 32'hFFFFFFFF);
    exception = 1'b0;
    checkOutput(0, SEL_CAUSE, 32'hFFFFFFFF, 32'h80000320, "cause_write_exc");
    checkOutput(0, SEL_RDATA, 32'hFFFFFFFF, 32'h80000320, "rdata_cause");
    step(2);

    for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
    while (sb.size() > 0) begin
      exp_t  e;
      string n;
      e = sb.pop_front();
      n = nm.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL %s: never compared, target cycle %0d, now %0d", n, e.cyc, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
